// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI user-request round-robin arbiter.
//   MAX_REQ / MAX_IDX_W : largest supported requester count and its index width
//   pick_t              : {found, idx} result of a rotate-priority search
//   idx_w()             : index width for a given requester count
//   rr_pick()           : first valid requester at or after ptr, wrapping mod num
package axi_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  // Scans ptr, ptr+1, ... (mod num). ptr < num and off < num, so one
  // conditional subtraction is enough to wrap the candidate index.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   num);
    pick_t p;
    int    j;
    p = '0;
    for (int off = 0; off < MAX_REQ; off++) begin
      if (off < num && !p.found) begin
        j = int'(ptr) + off;
        if (j >= num) j = j - num;
        if (valid[j]) begin
          p.found = 1'b1;
          p.idx   = MAX_IDX_W'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational rotate-priority picker.
//   valid : per-requester request valid
//   ptr   : requester with highest priority this cycle
//   found : at least one requester is valid
//   idx   : granted requester index (0 when found is low)
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  pick_t pick;
  logic  unused_pick_hi;

  always_comb pick = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(ptr), NUM_REQ);

  assign found = pick.found;
  assign idx   = pick.idx[IDX_W-1:0];

  // Index bits above IDX_W are always zero because idx < NUM_REQ.
  assign unused_pick_hi = ^pick.idx;

endmodule

// File: rtl/axi_user_req_arb.sv
// Round-robin arbiter sharing one AXI master user-request port among
// NUM_REQ requesters, with a registered output slice. One grant per cycle
// while the downstream port is ready.
//   clk, rst                  : clock, synchronous active-high reset
//   s_req_valid / s_req_ready : per-requester handshake (ready one-hot or zero)
//   s_req_*                   : requester i occupies slice [i*W +: W]
//   user_req_valid / _ready   : handshake towards the AXI master
//   user_req_*                : registered copy of the granted request
//   user_req_src              : index of the requester owning the output
// Optional build macro AXI_ARB_ID_TAG_EN: the top IDX_W bits of user_req_id
// are replaced by the grant index so responses can be routed back.
module axi_user_req_arb
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int BURST_WIDTH   = 2,
  parameter int MAX_BURST_LEN = 8,
  localparam int IDX_W        = idx_w(NUM_REQ),
  localparam int WD_W         = MAX_BURST_LEN * DATA_WIDTH,
  localparam int WS_W         = WD_W / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  input  logic [NUM_REQ-1:0]             s_req_we,
  input  logic [NUM_REQ*ID_WIDTH-1:0]    s_req_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   s_req_len,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]  s_req_size,
  input  logic [NUM_REQ*BURST_WIDTH-1:0] s_req_burst,
  input  logic [NUM_REQ*WD_W-1:0]        s_req_wdata,
  input  logic [NUM_REQ*WS_W-1:0]        s_req_wstrb,
  output logic                           user_req_valid,
  input  logic                           user_req_ready,
  output logic                           user_req_we,
  output logic [ID_WIDTH-1:0]            user_req_id,
  output logic [ADDR_WIDTH-1:0]          user_req_addr,
  output logic [LEN_WIDTH-1:0]           user_req_len,
  output logic [SIZE_WIDTH-1:0]          user_req_size,
  output logic [BURST_WIDTH-1:0]         user_req_burst,
  output logic [WD_W-1:0]                user_req_wdata,
  output logic [WS_W-1:0]                user_req_wstrb,
  output logic [IDX_W-1:0]               user_req_src
);

  typedef struct packed {
    logic                   we;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [WD_W-1:0]        wdata;
    logic [WS_W-1:0]        wstrb;
  } user_req_t;

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_found;
  logic                load_en;
  logic [ID_WIDTH-1:0] sel_id;
  logic [ID_WIDTH-1:0] out_id;
  user_req_t           sel_req;
  user_req_t           out_req;
  logic                out_valid;
  logic [IDX_W-1:0]    out_src;

  axi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid (s_req_valid),
    .ptr   (rr_ptr),
    .found (grant_found),
    .idx   (grant_idx)
  );

  // The output slot can take a new request when empty or being drained.
  assign load_en = !out_valid || user_req_ready;

  // NOTE: every variable driven from always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    s_req_ready = '0;
    if (!rst && load_en && grant_found) s_req_ready[grant_idx] = 1'b1;
  end

  assign sel_id = s_req_id[grant_idx*ID_WIDTH +: ID_WIDTH];

`ifdef AXI_ARB_ID_TAG_EN
  if (ID_WIDTH < IDX_W) begin : g_id_too_narrow
    $error("axi_user_req_arb: ID_WIDTH must be >= $clog2(NUM_REQ) for ID tagging");
    assign out_id = '0;
  end else if (ID_WIDTH == IDX_W) begin : g_id_tag_full
    logic unused_sel_id;
    assign out_id        = grant_idx;
    assign unused_sel_id = ^sel_id;
  end else begin : g_id_tag
    // Replaced top bits of the requester ID are intentionally dropped.
    logic unused_sel_id_hi;
    assign out_id           = {grant_idx, sel_id[ID_WIDTH-IDX_W-1:0]};
    assign unused_sel_id_hi = ^sel_id[ID_WIDTH-1 -: IDX_W];
  end
`else
  assign out_id = sel_id;
`endif

  always_comb begin
    sel_req       = '0;
    sel_req.we    = s_req_we[grant_idx];
    sel_req.id    = out_id;
    sel_req.addr  = s_req_addr [grant_idx*ADDR_WIDTH  +: ADDR_WIDTH];
    sel_req.len   = s_req_len  [grant_idx*LEN_WIDTH   +: LEN_WIDTH];
    sel_req.size  = s_req_size [grant_idx*SIZE_WIDTH  +: SIZE_WIDTH];
    sel_req.burst = s_req_burst[grant_idx*BURST_WIDTH +: BURST_WIDTH];
    sel_req.wdata = s_req_wdata[grant_idx*WD_W        +: WD_W];
    sel_req.wstrb = s_req_wstrb[grant_idx*WS_W        +: WS_W];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload registers are reset too, so the output bus reads
      // all-zero after reset rather than holding a stale request.
      out_valid <= 1'b0;
      out_req   <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_req   <= sel_req;
        out_src   <= grant_idx;
        rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign user_req_valid = out_valid;
  assign user_req_src   = out_src;
  assign user_req_we    = out_req.we;
  assign user_req_id    = out_req.id;
  assign user_req_addr  = out_req.addr;
  assign user_req_len   = out_req.len;
  assign user_req_size  = out_req.size;
  assign user_req_burst = out_req.burst;
  assign user_req_wdata = out_req.wdata;
  assign user_req_wstrb = out_req.wstrb;

endmodule

// File: tb/tb_axi_user_req_arb.sv
// Self-checking bench for axi_user_req_arb (NUM_REQ=4, ID_WIDTH=4).
// Build with +define+AXI_ARB_ID_TAG_EN to exercise the ID-tag variant.
module tb_axi_user_req_arb;

  localparam int N   = 4;
  localparam int WD  = 8 * 32;
  localparam int WS  = WD / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_req_valid = '0;
  logic [N-1:0]    s_req_ready;
  logic [N-1:0]    s_req_we;
  logic [N*4-1:0]  s_req_id;
  logic [N*32-1:0] s_req_addr;
  logic [N*8-1:0]  s_req_len;
  logic [N*3-1:0]  s_req_size;
  logic [N*2-1:0]  s_req_burst;
  logic [N*WD-1:0] s_req_wdata;
  logic [N*WS-1:0] s_req_wstrb;
  logic            user_req_valid;
  logic            user_req_ready = 1'b0;
  logic            user_req_we;
  logic [3:0]      user_req_id;
  logic [31:0]     user_req_addr;
  logic [7:0]      user_req_len;
  logic [2:0]      user_req_size;
  logic [1:0]      user_req_burst;
  logic [WD-1:0]   user_req_wdata;
  logic [WS-1:0]   user_req_wstrb;
  logic [1:0]      user_req_src;

  always #5 clk = ~clk;

  axi_user_req_arb dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_we(s_req_we), .s_req_id(s_req_id), .s_req_addr(s_req_addr),
    .s_req_len(s_req_len), .s_req_size(s_req_size), .s_req_burst(s_req_burst),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .user_req_valid(user_req_valid), .user_req_ready(user_req_ready),
    .user_req_we(user_req_we), .user_req_id(user_req_id),
    .user_req_addr(user_req_addr), .user_req_len(user_req_len),
    .user_req_size(user_req_size), .user_req_burst(user_req_burst),
    .user_req_wdata(user_req_wdata), .user_req_wstrb(user_req_wstrb),
    .user_req_src(user_req_src)
  );

  // Per-requester request contents, packed onto the s_req_* buses.
  logic          r_we    [N];
  logic [3:0]    r_id    [N];
  logic [31:0]   r_addr  [N];
  logic [7:0]    r_len   [N];
  logic [2:0]    r_size  [N];
  logic [1:0]    r_burst [N];
  logic [WD-1:0] r_wdata [N];
  logic [WS-1:0] r_wstrb [N];

  always_comb begin
    s_req_we = '0; s_req_id = '0; s_req_addr = '0; s_req_len = '0;
    s_req_size = '0; s_req_burst = '0; s_req_wdata = '0; s_req_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      s_req_we[i]            = r_we[i];
      s_req_id[i*4 +: 4]     = r_id[i];
      s_req_addr[i*32 +: 32] = r_addr[i];
      s_req_len[i*8 +: 8]    = r_len[i];
      s_req_size[i*3 +: 3]   = r_size[i];
      s_req_burst[i*2 +: 2]  = r_burst[i];
      s_req_wdata[i*WD +: WD] = r_wdata[i];
      s_req_wstrb[i*WS +: WS] = r_wstrb[i];
    end
  end

  typedef struct {
    logic [1:0]    src;
    logic          we;
    logic [3:0]    id;
    logic [31:0]   addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [WD-1:0] wdata;
    logic [WS-1:0] wstrb;
  } exp_rec_t;

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] exp_ready;
  } vec_t;

  int       checks = 0;
  int       errors = 0;
  exp_rec_t sb_q[$];
  exp_rec_t held;
  logic     exp_valid = 1'b0;
  vec_t     vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_rec_t make_rec(input int g);
    exp_rec_t r;
    r.src = 2'(g);
    r.we  = r_we[g];
`ifdef AXI_ARB_ID_TAG_EN
    r.id  = {2'(g), r_id[g][1:0]};
`else
    r.id  = r_id[g];
`endif
    r.addr = r_addr[g]; r.len = r_len[g]; r.size = r_size[g];
    r.burst = r_burst[g]; r.wdata = r_wdata[g]; r.wstrb = r_wstrb[g];
    return r;
  endfunction

  task automatic compare_rec(input string name, input exp_rec_t r);
    check({name, " src"},   64'(user_req_src),   64'(r.src));
    check({name, " we"},    64'(user_req_we),    64'(r.we));
    check({name, " id"},    64'(user_req_id),    64'(r.id));
    check({name, " addr"},  64'(user_req_addr),  64'(r.addr));
    check({name, " len"},   64'(user_req_len),   64'(r.len));
    check({name, " size"},  64'(user_req_size),  64'(r.size));
    check({name, " burst"}, 64'(user_req_burst), 64'(r.burst));
    check({name, " wdata_lo"}, user_req_wdata[63:0],    r.wdata[63:0]);
    check({name, " wdata_hi"}, user_req_wdata[WD-1 -: 64], r.wdata[WD-1 -: 64]);
    check({name, " wstrb"}, 64'(user_req_wstrb), 64'(r.wstrb));
  endtask

  // One cycle: drive at negedge, check the combinational ready, let the edge
  // happen, then check the registered output against the scoreboard.
  task automatic step(input string name, input logic [N-1:0] valid,
                      input logic ready, input logic [N-1:0] exp_ready);
    int  g;
    bit  pushed;
    exp_rec_t r;
    s_req_valid    = valid;
    user_req_ready = ready;
    #1;
    check({name, " s_req_ready"}, 64'(s_req_ready), 64'(exp_ready));
    pushed = 1'b0;
    g = 0;
    for (int i = 0; i < N; i++) if (exp_ready[i]) g = i;
    @(posedge clk);
    if (exp_ready != '0) begin
      sb_q.push_back(make_rec(g));
      exp_valid = 1'b1;
      pushed    = 1'b1;
    end else if (!exp_valid || ready) begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    check({name, " user_req_valid"}, 64'(user_req_valid), 64'(exp_valid));
    if (pushed) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: scoreboard empty, got 0 entries expected 1", name);
      end else begin
        r = sb_q.pop_front();
        held = r;
        compare_rec({name, " out"}, r);
      end
    end else if (exp_valid) begin
      compare_rec({name, " hold"}, held);
    end
  endtask

  task automatic do_reset(input int cycles, input logic [N-1:0] valid, input logic ready);
    rst = 1'b1;
    s_req_valid    = valid;
    user_req_ready = ready;
    for (int c = 0; c < cycles; c++) begin
      #1;
      check($sformatf("reset%0d s_req_ready", c), 64'(s_req_ready), 64'd0);
      @(negedge clk);
      check($sformatf("reset%0d user_req_valid", c), 64'(user_req_valid), 64'd0);
      check($sformatf("reset%0d user_req_src", c), 64'(user_req_src), 64'd0);
      check($sformatf("reset%0d user_req_addr", c), 64'(user_req_addr), 64'd0);
    end
    rst = 1'b0;
    exp_valid = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      r_we[i]    = i[0];
      r_addr[i]  = 32'h1000 * i;
      r_len[i]   = 8'(i + 2);
      r_size[i]  = 3'(i);
      r_burst[i] = 2'd1;
      r_wstrb[i] = {8{4'hF}} ^ WS'(i + 1);
      for (int b = 0; b < 8; b++) r_wdata[i][b*32 +: 32] = 32'hA000_0000 | (i << 8) | b;
    end
    r_id[0] = 4'h1; r_id[1] = 4'h6; r_id[2] = 4'hF; r_id[3] = 4'h9;

    vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{4'b1000, 1'b1, 4'b1000};
    vecs[6]  = '{4'b0001, 1'b1, 4'b0001};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000};
    vecs[8]  = '{4'b0101, 1'b0, 4'b0100};
    vecs[9]  = '{4'b0101, 1'b0, 4'b0000};
    vecs[10] = '{4'b0101, 1'b1, 4'b0001};
    vecs[11] = '{4'b0010, 1'b1, 4'b0010};
    vecs[12] = '{4'b0010, 1'b1, 4'b0010};

    @(negedge clk);

    // Reset with all requesters valid; first grant afterwards goes to req0.
    do_reset(4, 4'b1111, 1'b1);
    foreach (vecs[k])
      step($sformatf("vec%0d", k), vecs[k].valid, vecs[k].ready, vecs[k].exp_ready);

    // Continuous round robin from a fresh pointer.
    do_reset(1, 4'b0000, 1'b1);
    for (int k = 0; k < 8; k++)
      step($sformatf("rr%0d", k), 4'b1111, 1'b1, 4'(1 << (k % 4)));

    // Backpressure: req1 held stable for five stalled cycles, then req2 in the same cycle.
    do_reset(1, 4'b0000, 1'b1);
    step("bp_grant1", 4'b0010, 1'b1, 4'b0010);
    check("bp addr", 64'(user_req_addr), 64'h1000);
    check("bp len", 64'(user_req_len), 64'd3);
    for (int k = 0; k < 5; k++)
      step($sformatf("bp_stall%0d", k), 4'b1111, 1'b0, 4'b0000);
    step("bp_release", 4'b1111, 1'b1, 4'b0100);

    // ID tag on req2 (id 4'hF).
    step("idtag", 4'b0100, 1'b1, 4'b0100);
`ifdef AXI_ARB_ID_TAG_EN
    check("idtag literal", 64'(user_req_id), 64'hB);
`else
    check("idtag literal", 64'(user_req_id), 64'hF);
`endif

    // Reset while a stalled request is held: it is dropped and the pointer
    // returns to 0 (without the reset req3 would win next).
    step("mid_hold", 4'b1111, 1'b0, 4'b0000);
    do_reset(1, 4'b1111, 1'b0);
    step("post_reset", 4'b1111, 1'b1, 4'b0001);
    step("drain", 4'b0000, 1'b1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
